i2s_master_tx: RTL and testbench

- I2S bus master and transmitter: derives BCLK and LRC from the system clock and serializes stereo samples onto DACDAT.
- Drives a codec DAC whose audio interface is in slave mode, or feeds an FPGA-side I2S receiver in loopback tests.
- User side is a one-pair holding register with a valid/ready handshake; the frame timing is standard Philips I2S with 32-bit slots.

---
 rtl/i2s_pkg.sv | 20 ++
 rtl/i2s_bclk_gen.sv | 53 +++++
 rtl/i2s_master_tx.sv | 156 +++++++++++++++
 tb/tb_i2s_master_tx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S master transmitter.
// A standard Philips I2S frame has two 32-bit slots. A 6-bit counter walks
// the 64 bit positions of one frame.
package i2s_pkg;

    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;
    localparam int FCNT_W     = 6;

    localparam logic LRC_LEFT  = 1'b0;
    localparam logic LRC_RIGHT = 1'b1;

    typedef logic [FCNT_W-1:0]    fcnt_t;
    typedef logic [SLOT_BITS-1:0] slot_t;

    // This is the last bit position of a frame. The counter rests here while
    // the bus is idle, so the next fall event opens a new frame at position 0.
    localparam fcnt_t FCNT_LAST = fcnt_t'(FRAME_BITS - 1);

endpackage

// File: rtl/i2s_bclk_gen.sv
// This block generates the I2S bit clock from the system clock.
// aud_bclk toggles every HALF_DIV clk cycles while enable is high. The
// strobes are high during the clk cycle whose rising edge performs the
// matching toggle, so callers can update their state on that same edge.
//   clk, rst   : system clock, asynchronous active-high reset
//   enable     : run control; low holds the divider and aud_bclk at 0
//   aud_bclk   : registered bit clock
//   rise_stb   : the next clk edge takes aud_bclk from 0 to 1
//   fall_stb   : the next clk edge takes aud_bclk from 1 to 0
module i2s_bclk_gen #(
    parameter int HALF_DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic aud_bclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);

    logic [DIV_W-1:0] div_r;
    logic             bclk_r;
    logic             tc_s;

    // Terminal count of the half-period divider and the edge strobes.
    always_comb begin
        tc_s     = enable && (div_r == DIV_LAST);
        rise_stb = tc_s && !bclk_r;
        fall_stb = tc_s && bclk_r;
    end

    // Half-period divider and bit clock register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r  <= {DIV_W{1'b0}};
            bclk_r <= 1'b0;
        end else if (!enable) begin
            div_r  <= {DIV_W{1'b0}};
            bclk_r <= 1'b0;
        end else if (tc_s) begin
            div_r  <= {DIV_W{1'b0}};
            bclk_r <= ~bclk_r;
        end else begin
            div_r  <= div_r + 1'b1;
        end
    end

    assign aud_bclk = bclk_r;

endmodule

// File: rtl/i2s_master_tx.sv
// This block is an I2S bus master and transmitter with 32-bit slots in
// Philips framing.
// The user side is a single-pair holding register with a valid/ready
// handshake. At each frame boundary the held pair moves into the active
// registers. If the holding register is empty at that point, the frame
// sends silence and underrun pulses.
//   clk, rst          : system clock, asynchronous active-high reset
//   enable            : run control; low idles the bus
//   dac_l, dac_r      : stereo sample pair, WL bits, MSB first on the wire
//   dac_valid/ready   : handshake; a pair transfers when both are high
//   aud_bclk          : bit clock (receiver samples on its rising edge)
//   aud_lrc           : word select, 0 = left slot, 1 = right slot
//   aud_dacdat        : serial data, changes only on BCLK falling edges
//   frame_start       : one-clk pulse at each frame boundary
//   underrun          : one-clk pulse when a frame starts with no pair held
module i2s_master_tx
    import i2s_pkg::*;
#(
    parameter int WL       = 32,
    parameter int HALF_DIV = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [WL-1:0] dac_l,
    input  logic [WL-1:0] dac_r,
    input  logic          dac_valid,
    output logic          dac_ready,
    output logic          aud_bclk,
    output logic          aud_lrc,
    output logic          aud_dacdat,
    output logic          frame_start,
    output logic          underrun
);

    // A sample is left-justified in its 32-bit slot, and the unused low bits are sent as 0.
    function automatic slot_t pad_slot(input logic [WL-1:0] sample);
        pad_slot = slot_t'(sample) << (SLOT_BITS - WL);
    endfunction

    logic          fall_stb_s;
    logic          rise_stb_unused_s;
    logic          bclk_s;

    logic [WL-1:0] hold_l_r;
    logic [WL-1:0] hold_r_r;
    logic          full_r;

    slot_t         act_l_r;
    slot_t         act_r_r;
    fcnt_t         fcnt_r;
    logic          lrc_r;
    logic          dacdat_r;
    logic          frame_start_r;
    logic          underrun_r;

    fcnt_t         fcnt_next_s;
    logic          boundary_s;
    logic [4:0]    l_idx_s;
    logic [4:0]    r_idx_s;
    logic          data_bit_s;

    i2s_bclk_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_bclk_gen (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .aud_bclk (bclk_s),
        .rise_stb (rise_stb_unused_s),
        .fall_stb (fall_stb_s)
    );

    // Select the bit position for the next fall event and the data bit sent there.
    // Each slot's MSB goes out one bit after its LRC edge. As a result, position 0
    // carries the last bit of the previous right slot, which is still in act_r_r
    // on the boundary edge.
    always_comb begin
        fcnt_next_s = fcnt_r + 6'd1;
        boundary_s  = fall_stb_s && (fcnt_next_s == 6'd0);
        l_idx_s     = 5'(6'd32 - fcnt_next_s);
        r_idx_s     = 5'(7'd64 - {1'b0, fcnt_next_s});
        if (fcnt_next_s == 6'd0) begin
            data_bit_s = act_r_r[0];
        end else if (fcnt_next_s <= 6'd32) begin
            data_bit_s = act_l_r[l_idx_s];
        end else begin
            data_bit_s = act_r_r[r_idx_s];
        end
    end

    // Holding register and handshake. The holding register keeps working while
    // the bus is disabled. A pair written on a boundary edge while the register
    // is empty is too late for that frame and waits for the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_r   <= 1'b0;
            hold_l_r <= {WL{1'b0}};
            hold_r_r <= {WL{1'b0}};
        end else if (boundary_s && full_r) begin
            full_r   <= 1'b0;
        end else if (dac_valid && !full_r) begin
            full_r   <= 1'b1;
            hold_l_r <= dac_l;
            hold_r_r <= dac_r;
        end
    end

    // Frame sequencer: bit position, word select, serial data and frame pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt_r        <= FCNT_LAST;
            act_l_r       <= {SLOT_BITS{1'b0}};
            act_r_r       <= {SLOT_BITS{1'b0}};
            lrc_r         <= LRC_LEFT;
            dacdat_r      <= 1'b0;
            frame_start_r <= 1'b0;
            underrun_r    <= 1'b0;
        end else if (!enable) begin
            fcnt_r        <= FCNT_LAST;
            act_l_r       <= {SLOT_BITS{1'b0}};
            act_r_r       <= {SLOT_BITS{1'b0}};
            lrc_r         <= LRC_LEFT;
            dacdat_r      <= 1'b0;
            frame_start_r <= 1'b0;
            underrun_r    <= 1'b0;
        end else begin
            frame_start_r <= 1'b0;
            underrun_r    <= 1'b0;
            if (fall_stb_s) begin
                fcnt_r   <= fcnt_next_s;
                lrc_r    <= fcnt_next_s[FCNT_W-1] ? LRC_RIGHT : LRC_LEFT;
                dacdat_r <= data_bit_s;
                if (boundary_s) begin
                    frame_start_r <= 1'b1;
                    underrun_r    <= !full_r;
                    if (full_r) begin
                        act_l_r <= pad_slot(hold_l_r);
                        act_r_r <= pad_slot(hold_r_r);
                    end else begin
                        act_l_r <= {SLOT_BITS{1'b0}};
                        act_r_r <= {SLOT_BITS{1'b0}};
                    end
                end
            end
        end
    end

    assign dac_ready   = !full_r;
    assign aud_bclk    = bclk_s;
    assign aud_lrc     = lrc_r;
    assign aud_dacdat  = dacdat_r;
    assign frame_start = frame_start_r;
    assign underrun    = underrun_r;

endmodule

// File: tb/tb_i2s_master_tx.sv
// Testbench for i2s_master_tx. It runs two instances, with WL=32 and WL=24,
// in lockstep from the same clock, reset and enable.
// Each frame is captured bit by bit on BCLK rising edges. The captured
// frame is compared with the slot contents that the I2S framing rules
// predict for the pair queued for that frame.
module tb_i2s_master_tx;

    localparam int HALF_DIV = 2;
    localparam int BCLK_PER = 2 * HALF_DIV;
    localparam int FRAME_CLK = 64 * BCLK_PER;

    logic clk = 1'b0;
    logic rst;
    logic enable;

    logic [31:0] l32, r32;
    logic        v32;
    logic        ready32, bclk32, lrc32, dat32, fs32, ur32;

    logic [23:0] l24, r24;
    logic        v24;
    logic        ready24, bclk24, lrc24, dat24, fs24, ur24;

    always #5 clk = ~clk;

    i2s_master_tx #(.WL(32), .HALF_DIV(HALF_DIV)) dut32 (
        .clk(clk), .rst(rst), .enable(enable),
        .dac_l(l32), .dac_r(r32), .dac_valid(v32), .dac_ready(ready32),
        .aud_bclk(bclk32), .aud_lrc(lrc32), .aud_dacdat(dat32),
        .frame_start(fs32), .underrun(ur32)
    );

    i2s_master_tx #(.WL(24), .HALF_DIV(HALF_DIV)) dut24 (
        .clk(clk), .rst(rst), .enable(enable),
        .dac_l(l24), .dac_r(r24), .dac_valid(v24), .dac_ready(ready24),
        .aud_bclk(bclk24), .aud_lrc(lrc24), .aud_dacdat(dat24),
        .frame_start(fs24), .underrun(ur24)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [63:0] q32[$];
    logic [47:0] q24[$];
    logic        rdy32_seen = 1'b0;
    logic        rdy24_seen = 1'b0;
    int          acc32_cyc = 0;
    int          fs_cyc = 0;
    logic        rise_ev = 1'b0;
    logic        fs_ev = 1'b0;
    logic        prev_bclk = 1'b0;
    logic        prev32 = 1'b0;
    logic        prev24 = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clk step, sampled on the falling edge. It runs the valid/ready
    // sources and records BCLK rise and frame_start events.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (rst) begin
            q32.delete();
            q24.delete();
            v32 = 1'b0;
            v24 = 1'b0;
            rdy32_seen = 1'b0;
            rdy24_seen = 1'b0;
        end else begin
            if (v32 && rdy32_seen) begin
                void'(q32.pop_front());
                acc32_cyc = cyc;
            end
            if (v24 && rdy24_seen) void'(q24.pop_front());
            if (q32.size() > 0) begin
                v32 = 1'b1;
                {l32, r32} = q32[0];
            end else begin
                v32 = 1'b0;
            end
            if (q24.size() > 0) begin
                v24 = 1'b1;
                {l24, r24} = q24[0];
            end else begin
                v24 = 1'b0;
            end
            rdy32_seen = ready32;
            rdy24_seen = ready24;
        end
        rise_ev   = bclk32 && !prev_bclk;
        prev_bclk = bclk32;
        fs_ev     = fs32;
        if (fs_ev) fs_cyc = cyc;
    endtask

    task automatic wait_fs(input string tag, input int bound, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!fs_ev && n < bound);
        chk({tag, "_fs_seen"}, fs_ev, 1'b1);
    endtask

    task automatic wait_rise(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rise_ev && n < 2 * BCLK_PER + 2);
        chk({tag, "_rise_seen"}, rise_ev, 1'b1);
    endtask

    // Entered on the sample where this frame's frame_start is high. It
    // returns on the sample where the next frame_start is high.
    task automatic run_frame(input string tag, input logic [31:0] el32, input logic [31:0] er32,
                             input logic [23:0] el24, input logic [23:0] er24, input logic eur);
        logic [63:0] b32, b24, lr;
        logic [31:0] gl32, gr32, gl24, gr24, xl24, xr24;
        int f0, r0c, r1c, n;
        f0 = cyc;
        r0c = 0;
        r1c = 0;
        chk({tag, "_ur32"}, ur32, eur);
        chk({tag, "_ur24"}, ur24, eur);
        chk({tag, "_fs24"}, fs24, 1'b1);
        for (int i = 0; i < 64; i++) begin
            wait_rise(tag);
            if (i == 0) r0c = cyc;
            if (i == 1) r1c = cyc;
            b32[i] = dat32;
            b24[i] = dat24;
            lr[i]  = lrc32;
        end
        xl24 = {el24, 8'h00};
        xr24 = {er24, 8'h00};
        gl32 = 32'h0; gr32 = 32'h0; gl24 = 32'h0; gr24 = 32'h0;
        for (int i = 1; i <= 32; i++) begin
            gl32[32 - i] = b32[i];
            gl24[32 - i] = b24[i];
        end
        for (int i = 33; i <= 63; i++) begin
            gr32[64 - i] = b32[i];
            gr24[64 - i] = b24[i];
        end
        chk({tag, "_bit0_32"}, b32[0], prev32);
        chk({tag, "_bit0_24"}, b24[0], prev24);
        chk({tag, "_left32"}, gl32, el32);
        chk({tag, "_right32"}, gr32[31:1], er32[31:1]);
        chk({tag, "_left24"}, gl24, xl24);
        chk({tag, "_right24"}, gr24[31:1], xr24[31:1]);
        chk({tag, "_lrc"}, lr, 64'hFFFF_FFFF_0000_0000);
        chk({tag, "_bclk_period"}, r1c - r0c, BCLK_PER);
        prev32 = er32[0];
        prev24 = xr24[0];
        wait_fs(tag, 4 * BCLK_PER, n);
        chk({tag, "_frame_period"}, cyc - f0, FRAME_CLK);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_bclk"}, {bclk32, bclk24}, 2'b00);
        chk({tag, "_lrc"}, {lrc32, lrc24}, 2'b00);
        chk({tag, "_dat"}, {dat32, dat24}, 2'b00);
        chk({tag, "_fs_ur"}, {fs32, fs24, ur32, ur24}, 4'b0000);
    endtask

    initial begin
        int n, fs1, nz;
        logic [31:0] bl, br, cl, cr, dl, dr;
        logic [23:0] bl24, br24, cl24, cr24, dl24, dr24;
        rst = 1'b1; enable = 1'b0;
        v32 = 1'b0; v24 = 1'b0;
        l32 = 32'h0; r32 = 32'h0; l24 = 24'h0; r24 = 24'h0;
        bl = $urandom; br = $urandom; cl = $urandom; cr = $urandom;
        dl = $urandom; dr = $urandom;
        bl24 = 24'($urandom); br24 = 24'($urandom); cl24 = 24'($urandom);
        cr24 = 24'($urandom); dl24 = 24'($urandom); dr24 = 24'($urandom);

        // Reset state
        repeat (3) tick();
        chk_idle("reset");
        chk("reset_ready", {ready32, ready24}, 2'b11);

        // Pair A is written while the bus is disabled. Pair B is then held
        // on valid while the holding register is full.
        rst = 1'b0;
        q32.push_back({32'hA5A5A5A5, 32'h3C3C3C3C});
        q32.push_back({bl, br});
        q24.push_back({24'h123456, 24'hFEDCBA});
        q24.push_back({bl24, br24});
        repeat (4) tick();
        chk("held_ready", {ready32, ready24}, 2'b00);
        chk_idle("disabled");

        // The first frame starts 2*HALF_DIV clk after enable rises.
        enable = 1'b1;
        wait_fs("start", 4 * BCLK_PER, n);
        chk("start_latency", n, BCLK_PER);
        chk("start_ready", {ready32, ready24}, 2'b11);
        fs1 = fs_cyc;
        prev32 = 1'b0; prev24 = 1'b0;
        run_frame("frameA", 32'hA5A5A5A5, 32'h3C3C3C3C, 24'h123456, 24'hFEDCBA, 1'b0);
        chk("b_accept_delay", acc32_cyc - fs1, 1);
        chk("frameB_ready", {ready32, ready24}, 2'b11);

        run_frame("frameB", bl, br, bl24, br24, 1'b0);

        // Nothing is held for this frame, so it underruns. Pair C queued now is used in the next frame.
        chk("under_ready", {ready32, ready24}, 2'b11);
        q32.push_back({cl, cr});
        q24.push_back({cl24, cr24});
        run_frame("frameU", 32'h0, 32'h0, 24'h0, 24'h0, 1'b1);

        // Frame C is cut off at fcnt 40 by disabling. Pair D waits in the holding register.
        q32.push_back({dl, dr});
        q24.push_back({dl24, dr24});
        chk("frameC_ur", ur32, 1'b0);
        for (int i = 0; i < 41; i++) wait_rise("frameC");
        enable = 1'b0;
        tick();
        chk_idle("dis_first");
        nz = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if ({bclk32, lrc32, dat32, fs32, ur32, bclk24, lrc24, dat24, fs24, ur24} != 10'b0) nz++;
        end
        chk("dis_nonzero_cycles", nz, 0);
        chk("dis_ready", {ready32, ready24}, 2'b00);
        enable = 1'b1;
        wait_fs("reen", 4 * BCLK_PER, n);
        chk("reen_latency", n, BCLK_PER);
        prev32 = 1'b0; prev24 = 1'b0;
        run_frame("frameD", dl, dr, dl24, dr24, 1'b0);

        // Pair E is accepted, and then reset is asserted at fcnt 20.
        q32.push_back({32'hDEADBEEF, 32'h01234567});
        q24.push_back({24'hABCDEF, 24'h765432});
        for (int i = 0; i < 21; i++) wait_rise("preRst");
        chk("preRst_ready", {ready32, ready24}, 2'b00);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("rst_mid");
        chk("rst_mid_ready", {ready32, ready24}, 2'b11);
        repeat (2) tick();
        rst = 1'b0;
        wait_fs("postRst", 4 * BCLK_PER, n);
        chk("postRst_latency", n, BCLK_PER);
        prev32 = 1'b0; prev24 = 1'b0;
        run_frame("frameLost", 32'h0, 32'h0, 24'h0, 24'h0, 1'b1);
        chk("final_ready", {ready32, ready24}, 2'b11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
